// File: rtl/vedic_arb_pkg.sv
// rtl/vedic_arb_pkg.sv - shared types and helpers for the vedic multiplier arbiter
package vedic_arb_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

  localparam int MAX_REQ = 16;

  // Written as a compare so synthesis never builds a divider for the wrap.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting at ptr
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vedic_mult.sv
// rtl/vedic_mult.sv - combinational unsigned vedic (Urdhva Tiryagbhyam) multiplier
// WIDTH must be a power of two >= 2; larger widths recurse on half-width blocks.
module vedic_mult #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  if (WIDTH == 2) begin : g_base
    logic c1;
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_rec
    localparam int H = WIDTH / 2;
    logic [WIDTH-1:0]   ll, lh, hl, hh;
    logic [2*WIDTH-1:0] mid;

    vedic_mult #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(ll));
    vedic_mult #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(lh));
    vedic_mult #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(hl));
    vedic_mult #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(hh));

    // Cross terms land at weight 2^H; the full product always fits 2*WIDTH bits.
    assign mid = {{H{1'b0}}, lh, {H{1'b0}}} + {{H{1'b0}}, hl, {H{1'b0}}};
    assign p   = {{WIDTH{1'b0}}, ll} + mid + {hh, {WIDTH{1'b0}}};
  end

endmodule

// File: rtl/vedic_mult_arbiter.sv
// rtl/vedic_mult_arbiter.sv - round-robin sharing of one registered vedic multiplier
// Optional op_count port/counter enabled by VEDIC_ARB_PERF_CNT_EN.
module vedic_mult_arbiter
  import vedic_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic [ID_W-1:0]          rsp_id
`ifdef VEDIC_ARB_PERF_CNT_EN
  ,
  output logic [31:0]              op_count
`endif
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] mult_p;
  logic               arb_en;
  logic               req_hs;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en = (state == IDLE) && !rst;
  assign req_hs = |(req_valid & req_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  vedic_mult #(.WIDTH(WIDTH)) u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            op_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            op_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            id_q   <= grant_idx;
            rr_ptr <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_prod  <= mult_p;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef VEDIC_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready && (op_count != 32'hFFFF_FFFF)) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mult_arbiter.sv
// tb/tb_vedic_mult_arbiter.sv - directed and random checks of vedic_mult_arbiter against a transaction model
module tb_vedic_mult_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_prod;
  logic [1:0]       rsp_id;
`ifdef VEDIC_ARB_PERF_CNT_EN
  logic [31:0]      op_count;
`endif

  vedic_mult_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id)
`ifdef VEDIC_ARB_PERF_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int prod;
    int due;
  } exp_t;

  exp_t q[$];
  int   log_id[$];
  int   log_prod[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;
  int   cyc    = 0;
  int   done_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model, clock.
  task automatic run_cycle(input logic [N-1:0] v, input logic [N*W-1:0] a,
                           input logic [N*W-1:0] b, input logic rr);
    logic [N-1:0] er;
    int           g;
    bit           ev;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    g  = (q.size() == 0) ? pick(v) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ev = (q.size() > 0) && (cyc >= q[0].due);
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, ev);
    if (ev) begin
      check("rsp_prod", rsp_prod, q[0].prod);
      check("rsp_id", rsp_id, q[0].id);
    end
`ifdef VEDIC_ARB_PERF_CNT_EN
    check("op_count", op_count, done_m);
`endif
    if (ev && rr) begin
      log_id.push_back(int'(rsp_id));
      log_prod.push_back(int'(rsp_prod));
      void'(q.pop_front());
      done_m++;
    end
    if (g >= 0) begin
      q.push_back('{g, int'(a[g*W +: W]) * int'(b[g*W +: W]), cyc + 2});
      ptr_m = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_prod", rsp_prod, 0);
      check("rst_rsp_id", rsp_id, 0);
`ifdef VEDIC_ARB_PERF_CNT_EN
      check("rst_op_count", op_count, 0);
`endif
    end
    rst    = 1'b0;
    ptr_m  = 0;
    done_m = 0;
    q.delete();
    log_id.delete();
    log_prod.delete();
  endtask

  int exp_ids[5]   = '{0, 1, 2, 3, 0};
  int exp_prods[5] = '{3, 6, 9, 12, 3};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    do_reset();

    // single op from requester 2 with the largest operands
    run_cycle(4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(4'b0000, '0, '0, 1'b1);
    check("single_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      check("single_id", log_id[0], 2);
      check("single_prod", log_prod[0], 16'hFE01);
    end

    // round robin with everyone requesting
    do_reset();
    for (int i = 0; i < 15; i++) run_cycle(4'b1111, 32'h0403_0201, 32'h0303_0303, 1'b1);
    check("rr_count", log_id.size(), 5);
    if (log_id.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_id", log_id[i], exp_ids[i]);
        check("rr_prod", log_prod[i], exp_prods[i]);
      end
    end

    // backpressure: response held while operands keep changing
    for (int i = 0; i < 12; i++) run_cycle(4'b1111, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(4'b1111, $urandom, $urandom, 1'b1);

    // pointer wrap: serve 0,1,2 so the pointer sits at 3, then only requester 1
    do_reset();
    for (int r = 0; r < 3; r++) begin
      run_cycle(4'(1 << r), $urandom, $urandom, 1'b1);
      run_cycle(4'b0000, '0, '0, 1'b1);
      run_cycle(4'b0000, '0, '0, 1'b1);
    end
    run_cycle(4'b0010, 32'h0000_0700, 32'h0000_0500, 1'b1);
    run_cycle(4'b0000, '0, '0, 1'b1);
    run_cycle(4'b0000, '0, '0, 1'b1);
    run_cycle(4'b1110, $urandom, $urandom, 1'b1);
    run_cycle(4'b0000, '0, '0, 1'b1);
    run_cycle(4'b0000, '0, '0, 1'b1);
    check("wrap_count", log_id.size(), 5);
    if (log_id.size() == 5) begin
      check("wrap_id1", log_id[3], 1);
      check("wrap_prod1", log_prod[3], 35);
      check("wrap_id2", log_id[4], 2);
    end

    // reset while a result is held: it must vanish
    for (int i = 0; i < 4; i++) run_cycle(4'b1111, $urandom, $urandom, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) run_cycle(4'b1111, $urandom, $urandom, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vedic_mult_arbiter.md
Name: vedic_mult_arbiter

Overview:
- Shares one combinational vedic_mult instance of width WIDTH among NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel.
- Results return on a single valid/ready response channel, tagged with the requester index.
- Operands and product are registered, so the multiplier tree sits between two flop stages.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- WIDTH, 8, operand width; power of two, at least 2, as required by vedic_mult recursion.
- ID_W, $clog2(NUM_REQ), width of the response tag; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_prod  out  2*WIDTH  unsigned product a*b.
- rsp_id  out  ID_W  index of the originating requester.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high; port names are clk and rst.
  - On rst: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_prod=0, rsp_id=0, operand regs=0.
  - rst mid-operation discards any in-flight or held result with no response.
- FSM states are IDLE, CALC and RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - No valid requests: stay in IDLE with all req_ready=0.
  - Handshake (req_valid[g] & req_ready[g]): latch a/b of g into op regs, latch g into id reg, set rr_ptr=(g+1) mod NUM_REQ, go to CALC.
- CALC:
  - req_ready=0.
  - Register vedic_mult(op_a, op_b) into rsp_prod and the id reg into rsp_id.
  - Next state RESP with rsp_valid=1.
- RESP:
  - rsp_valid=1; rsp_prod and rsp_id stay stable until the handshake.
  - req_ready=0.
  - On rsp_ready=1: rsp_valid=0 next cycle, go to IDLE.
  - rsp_ready held low: remain in RESP indefinitely (backpressure).
- Timing:
  - Latency: request handshake at cycle N gives rsp_valid at N+2.
  - Throughput: at most one operation per 3 cycles with rsp_ready tied high.
- Request-side rules:
  - A requester may drop req_valid before being granted; no protocol error results.
  - The grant is re-evaluated every IDLE cycle.
  - Operands are sampled only in the handshake cycle.
- Arithmetic:
  - Unsigned.
  - The full 2*WIDTH product has no truncation; 0xFF*0xFF=0xFE01 at WIDTH=8.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- Simultaneous events:
  - rsp_ready asserted while in IDLE or CALC is ignored.
  - New req_valid edges during CALC/RESP wait for IDLE.

Optional Feature:
- Macro: VEDIC_ARB_PERF_CNT_EN.
- When defined:
  - Adds output port op_count (out, 32 bits).
  - op_count increments by 1 on each response handshake (rsp_valid & rsp_ready), saturates at 0xFFFFFFFF, and resets to 0 on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vedic_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t.
  - localparam MAX_REQ=16.
  - Function rr_next(ptr, n) returning (ptr+1) mod n.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ; inputs req, ptr, en; output one-hot grant plus encoded grant index.
  - Purely combinational.
- vedic_mult is instantiated unchanged inside the top.

Test Plan:
- Reset/idle: assert rst for 2 cycles mid-RESP -> rsp_valid=0, req_ready=0, rr_ptr=0 next cycle; no response emitted.
- Single op: req 2 sends a=0xFF, b=0xFF at cycle N, rsp_ready=1 -> rsp_valid at N+2, rsp_prod=0xFE01, rsp_id=2, one-cycle pulse.
- Round-robin: all four req_valid high continuously, operands a=i+1, b=3 -> rsp_id sequence 0,1,2,3,0, products 3,6,9,12,3.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_prod/rsp_id stable, all req_ready=0; release -> IDLE, next grant proceeds.
- Pointer wrap: rr_ptr=3 with only req 1 valid -> grant 1, rr_ptr becomes 2.
- With VEDIC_ARB_PERF_CNT_EN: 5 completed ops -> op_count=5; an op aborted by rst is not counted, and rst clears op_count to 0.
